lm07_responder: RTL and testbench

Synthesizable LM07-compatible 3-wire SPI responder: the sensor end of the CS/SCK/SIO link that the temperature-reader master drives. It oversamples CS and SCK on SYSCLK, shifts a 16-bit temperature word out on SIO, then accepts a 16-bit configuration word back on the same wire. It sits in FPGA builds and benches in place of a physical LM07. Temperature comes from a parallel input; configuration results are presented on parallel outputs.

---
 rtl/lm07_responder.sv | 143 ++++++++++++++
 tb/tb_lm07_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lm07_responder.sv
// LM07-compatible 3-wire SPI responder: oversamples CS/SCK on SYSCLK, shifts a
// 16-bit temperature word out on SIO, then takes a 16-bit configuration word back.
module lm07_responder #(
  parameter logic [15:0] DEV_ID   = 16'h800F,
  parameter logic [15:0] SHDN_CMD = 16'hFFFF
) (
  input  logic        SYSCLK,
  input  logic        RSTN,
  input  logic        CS,
  input  logic        SCK,
  input  logic        SIO_IN,
  output logic        SIO_OUT,
  output logic        SIO_OE,
  input  logic [15:0] temp_in,
  input  logic        temp_we,
  output logic [15:0] cfg_out,
  output logic        cfg_valid,
  output logic        shutdown,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, TX, RX, DONE} state_t;

  // Pipes: [0] and [1] are the synchronizer, [2] is the edge-detect copy.
  logic [2:0]  cs_pipe_q, cs_pipe_d;
  logic [2:0]  sck_pipe_q, sck_pipe_d;
  logic [1:0]  sio_pipe_q, sio_pipe_d;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] rx_q, rx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        oe_q, oe_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] cfg_q, cfg_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic        shutdown_q, shutdown_d;

  logic        cs_fall, cs_rise, sck_fall, sck_rise, sio_bit;
  logic [15:0] rx_word;

  assign cs_fall  =  cs_pipe_q[2]  & ~cs_pipe_q[1];
  assign cs_rise  = ~cs_pipe_q[2]  &  cs_pipe_q[1];
  assign sck_fall =  sck_pipe_q[2] & ~sck_pipe_q[1];
  assign sck_rise = ~sck_pipe_q[2] &  sck_pipe_q[1];
  assign sio_bit  =  sio_pipe_q[1];
  assign rx_word  = {rx_q[14:0], sio_bit};

  always_comb begin
    cs_pipe_d   = {cs_pipe_q[1:0], CS};
    sck_pipe_d  = {sck_pipe_q[1:0], SCK};
    sio_pipe_d  = {sio_pipe_q[0], SIO_IN};
    state_d     = state_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    oe_d        = oe_q;
    cfg_d       = cfg_q;
    cfg_valid_d = 1'b0;
    shutdown_d  = shutdown_q;
    shadow_d    = temp_we ? temp_in : shadow_q;

    // CS edges take priority over any SCK edge seen in the same cycle.
    if (cs_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      cnt_d   = 4'd0;
    end else if (cs_fall) begin
      shift_d = shutdown_q ? DEV_ID : shadow_q;
      cnt_d   = 4'd0;
      oe_d    = 1'b1;
      state_d = TX;
    end else begin
      case (state_q)
        TX: begin
          if (sck_fall) begin
            shift_d = {shift_q[14:0], 1'b0};
            if (cnt_q == 4'd15) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = RX;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        RX: begin
          if (sck_rise) begin
            rx_d = rx_word;
            if (cnt_q == 4'd15) begin
              cfg_d       = rx_word;
              cfg_valid_d = 1'b1;
              shutdown_d  = (rx_word == SHDN_CMD);
              cnt_d       = 4'd0;
              state_d     = DONE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RSTN) begin
      cs_pipe_q   <= 3'b111;
      sck_pipe_q  <= 3'b000;
      sio_pipe_q  <= 2'b00;
      state_q     <= IDLE;
      shift_q     <= 16'h0000;
      rx_q        <= 16'h0000;
      cnt_q       <= 4'd0;
      oe_q        <= 1'b0;
      shadow_q    <= 16'h0000;
      cfg_q       <= 16'h0000;
      cfg_valid_q <= 1'b0;
      shutdown_q  <= 1'b0;
    end else begin
      cs_pipe_q   <= cs_pipe_d;
      sck_pipe_q  <= sck_pipe_d;
      sio_pipe_q  <= sio_pipe_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      oe_q        <= oe_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      shutdown_q  <= shutdown_d;
    end
  end

  assign SIO_OUT   = shift_q[15];
  assign SIO_OE    = oe_q;
  assign cfg_out   = cfg_q;
  assign cfg_valid = cfg_valid_q;
  assign shutdown  = shutdown_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lm07_responder.sv
// Bench for lm07_responder: an SPI master model drives the pins, a reference model
// predicts read words and config results, and monitors compare via scoreboard queues.
module tb_lm07_responder;

  localparam logic [15:0] DEV_ID   = 16'h800F;
  localparam logic [15:0] SHDN_CMD = 16'hFFFF;

  logic        SYSCLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        CS = 1'b1;
  logic        SCK = 1'b0;
  logic        SIO_IN = 1'b0;
  logic        SIO_OUT, SIO_OE;
  logic [15:0] temp_in = 16'h0000;
  logic        temp_we = 1'b0;
  logic [15:0] cfg_out;
  logic        cfg_valid, shutdown, busy;

  typedef struct {
    logic [15:0] cfg;
    logic        shdn;
  } cfg_exp_t;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] m_shadow = 16'h0000;
  logic [15:0] m_cfg = 16'h0000;
  logic        m_shdn = 1'b0;

  logic [15:0] exp_rd[$];
  logic [15:0] got_rd[$];
  cfg_exp_t    exp_cfg[$];
  cfg_exp_t    cur_cfg;
  logic [15:0] cur_exp_rd, cur_got_rd;

  lm07_responder #(.DEV_ID(DEV_ID), .SHDN_CMD(SHDN_CMD)) dut (
    .SYSCLK(SYSCLK), .RSTN(RSTN), .CS(CS), .SCK(SCK), .SIO_IN(SIO_IN),
    .SIO_OUT(SIO_OUT), .SIO_OE(SIO_OE), .temp_in(temp_in), .temp_we(temp_we),
    .cfg_out(cfg_out), .cfg_valid(cfg_valid), .shutdown(shutdown), .busy(busy)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic loadTemp(input logic [15:0] v);
    temp_in = v;
    temp_we = 1'b1;
    #10;
    temp_we = 1'b0;
    m_shadow = v;
  endtask

  // One master transaction: 16 read clocks, then rx_bits write clocks, then CS high.
  task automatic applyStimulus(input logic [15:0] wr, input int rx_bits,
                               input bit mid_we, input logic [15:0] mid_val);
    logic [15:0] rd;
    rd = 16'h0000;
    exp_rd.push_back(m_shdn ? DEV_ID : m_shadow);
    if (rx_bits == 16) begin
      m_cfg  = wr;
      m_shdn = (wr == SHDN_CMD);
      exp_cfg.push_back('{wr, (wr == SHDN_CMD)});
    end
    CS = 1'b0;
    #20;
    checkOutput("oe_early_after_cs_fall", 16'(SIO_OE), 16'd0);
    #10;
    checkOutput("oe_after_cs_fall", 16'(SIO_OE), 16'd1);
    checkOutput("busy_after_cs_fall", 16'(busy), 16'd1);
    #30;
    for (int i = 0; i < 16; i++) begin
      SCK = 1'b1;
      rd[15-i] = SIO_OUT;
      checkOutput("oe_during_tx", 16'(SIO_OE), 16'd1);
      #40;
      SCK = 1'b0;
      if (i == 15) begin
        #20;
        checkOutput("oe_before_tx_end", 16'(SIO_OE), 16'd1);
        #10;
        checkOutput("oe_after_tx_end", 16'(SIO_OE), 16'd0);
        #10;
      end else if (mid_we && i == 5) begin
        temp_in = mid_val;
        temp_we = 1'b1;
        #10;
        temp_we = 1'b0;
        m_shadow = mid_val;
        #30;
      end else begin
        #40;
      end
    end
    got_rd.push_back(rd);
    for (int j = 0; j < rx_bits; j++) begin
      SIO_IN = wr[15-j];
      #40;
      SCK = 1'b1;
      if (j == 15) begin
        #20;
        checkOutput("cfg_valid_early", 16'(cfg_valid), 16'd0);
        #10;
        checkOutput("cfg_valid_latency", 16'(cfg_valid), 16'd1);
        #10;
      end else begin
        #40;
      end
      SCK = 1'b0;
    end
    #40;
    CS = 1'b1;
    SIO_IN = 1'b0;
    #30;
    checkOutput("oe_after_cs_rise", 16'(SIO_OE), 16'd0);
    checkOutput("busy_after_cs_rise", 16'(busy), 16'd0);
    #30;
    checkOutput("cfg_out_steady", cfg_out, m_cfg);
    checkOutput("shutdown_steady", 16'(shutdown), 16'(m_shdn));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_sio_out"}, 16'(SIO_OUT), 16'd0);
    checkOutput({tag, "_sio_oe"}, 16'(SIO_OE), 16'd0);
    checkOutput({tag, "_cfg_out"}, cfg_out, 16'h0000);
    checkOutput({tag, "_cfg_valid"}, 16'(cfg_valid), 16'd0);
    checkOutput({tag, "_shutdown"}, 16'(shutdown), 16'd0);
    checkOutput({tag, "_busy"}, 16'(busy), 16'd0);
  endtask

  task automatic resetMidTx();
    CS = 1'b0;
    #60;
    for (int i = 0; i < 4; i++) begin
      SCK = 1'b1;
      #40;
      SCK = 1'b0;
      #40;
    end
    RSTN = 1'b0;
    CS = 1'b1;
    #10;
    checkResetValues("mid_tx_reset");
    RSTN = 1'b1;
    m_shadow = 16'h0000;
    m_cfg = 16'h0000;
    m_shdn = 1'b0;
    repeat (10) begin
      #10;
      checkOutput("oe_held_after_reset", 16'(SIO_OE), 16'd0);
    end
  endtask

  // Config monitor pops one expectation per cfg_valid pulse; read monitor pairs captured words.
  always @(negedge SYSCLK) begin
    if (cfg_valid) begin
      if (exp_cfg.size() == 0) begin
        checkOutput("cfg_valid_unexpected", 16'(cfg_valid), 16'd0);
      end else begin
        cur_cfg = exp_cfg.pop_front();
        checkOutput("cfg_out_on_valid", cfg_out, cur_cfg.cfg);
        checkOutput("shutdown_on_valid", 16'(shutdown), 16'(cur_cfg.shdn));
      end
    end
    while (got_rd.size() > 0 && exp_rd.size() > 0) begin
      cur_got_rd = got_rd.pop_front();
      cur_exp_rd = exp_rd.pop_front();
      checkOutput("read_word", cur_got_rd, cur_exp_rd);
    end
  end

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, rx;
    logic [15:0] wr;
    @(negedge SYSCLK);
    repeat (3) @(negedge SYSCLK);
    checkResetValues("reset");
    RSTN = 1'b1;
    #40;

    // SCK activity with CS held high must be ignored.
    for (int i = 0; i < 10; i++) begin
      SCK = ~SCK;
      #40;
      checkOutput("idle_sck_oe", 16'(SIO_OE), 16'd0);
      checkOutput("idle_sck_busy", 16'(busy), 16'd0);
    end
    SCK = 1'b0;
    #40;

    loadTemp(16'h0C80);
    applyStimulus(16'h0000, 0, 1'b0, 16'h0000);
    applyStimulus(16'hFFFF, 16, 1'b0, 16'h0000);
    applyStimulus(16'h0000, 16, 1'b0, 16'h0000);
    applyStimulus(16'h5A5A, 16, 1'b0, 16'h0000);

    applyStimulus(16'h1234, 16, 1'b1, 16'h1900);
    applyStimulus(16'h0001, 16, 1'b0, 16'h0000);

    applyStimulus(16'hFFFF, 16, 1'b0, 16'h0000);
    applyStimulus(16'h0000, 8, 1'b0, 16'h0000);
    applyStimulus(16'hABCD, 16, 1'b0, 16'h0000);

    applyStimulus(16'hFFFF, 16, 1'b0, 16'h0000);
    resetMidTx();
    applyStimulus(16'h1111, 16, 1'b0, 16'h0000);
    loadTemp(16'h7FF8);
    applyStimulus(16'h2222, 16, 1'b0, 16'h0000);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) loadTemp(16'($urandom));
      wr = ($urandom_range(0, 3) == 0) ? SHDN_CMD : 16'($urandom);
      r = $urandom_range(0, 3);
      rx = (r == 0) ? 0 : (r == 1) ? 8 : 16;
      applyStimulus(wr, rx, ($urandom_range(0, 3) == 0), 16'($urandom));
    end

    #200;
    checkOutput("cfg_queue_drained", 16'(exp_cfg.size()), 16'd0);
    checkOutput("read_queue_drained", 16'(exp_rd.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
